// File: rtl/dram_pkg.sv
// Shared types and default timing for the DRAM timing-signal producer.
// All latencies are in controller clock cycles.
package dram_pkg;

    typedef enum logic [2:0] {
        CMD_ACT = 3'd0,
        CMD_RD  = 3'd1,
        CMD_WR  = 3'd2,
        CMD_PRE = 3'd3,
        CMD_REF = 3'd4
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ACT_W,
        RD_W,
        WR_W,
        PRE_W,
        REF_W
    } timer_state_t;

    localparam int CNT_W_DEF   = 16;
    localparam int T_RCD_DEF   = 4;
    localparam int T_CL_DEF    = 5;
    localparam int T_CWL_DEF   = 4;
    localparam int T_BURST_DEF = 4;
    localparam int T_WR_DEF    = 6;
    localparam int T_RP_DEF    = 4;
    localparam int T_RFC_DEF   = 16;
    localparam int T_REFI_DEF  = 64;

    // True when a latency is at least one cycle and representable in w bits.
    function automatic bit timing_fits(input int t, input int w);
        return (t >= 1) && ((w >= 31) || (t < (1 << w)));
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer: raises rf_req after T_REFI cycles
// and holds it until a REF is accepted, which also restarts the interval.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int T_REFI = T_REFI_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic ref_ack,
    output logic rf_req
);

    localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(T_REFI - 1);

    logic [CNT_W-1:0] rfc_cnt_q, rfc_cnt_d;
    logic             rf_req_q, rf_req_d;

    // REF acceptance outranks the threshold so a coincident REF leaves rf_req low.
    always_comb begin
        rfc_cnt_d = rfc_cnt_q;
        rf_req_d  = rf_req_q;
        if (ref_ack) begin
            rfc_cnt_d = '0;
            rf_req_d  = 1'b0;
        end else if (rfc_cnt_q == REFI_LAST) begin
            rf_req_d  = 1'b1;
        end else begin
            rfc_cnt_d = rfc_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rfc_cnt_q <= '0;
            rf_req_q  <= 1'b0;
        end else begin
            rfc_cnt_q <= rfc_cnt_d;
            rf_req_q  <= rf_req_d;
        end
    end

    assign rf_req = rf_req_q;

endmodule

// File: rtl/dram_timing_ctrl.sv
// Latency FSM for issued DRAM commands: times each command from its issue
// cycle, drives the data windows and done/clear pulses, and hosts the refresh timer.
module dram_timing_ctrl
    import dram_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int T_RCD   = T_RCD_DEF,
    parameter int T_CL    = T_CL_DEF,
    parameter int T_CWL   = T_CWL_DEF,
    parameter int T_BURST = T_BURST_DEF,
    parameter int T_WR    = T_WR_DEF,
    parameter int T_RP    = T_RP_DEF,
    parameter int T_RFC   = T_RFC_DEF,
    parameter int T_REFI  = T_REFI_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic cmd_valid,
    input  cmd_t cmd,
    output logic busy,
    output logic tACT_done,
    output logic tWR_done,
    output logic tRD_done,
    output logic tPRE_done,
    output logic tREF_done,
    output logic rf_req,
    output logic wr_en,
    output logic rd_en,
    output logic clear
);

    localparam logic [CNT_W:0] RD_SPAN = (CNT_W+1)'(T_CL) + (CNT_W+1)'(T_BURST);
    localparam logic [CNT_W:0] WR_SPAN = (CNT_W+1)'(T_CWL) + (CNT_W+1)'(T_BURST)
                                       + (CNT_W+1)'(T_WR);

    if (!(timing_fits(T_RCD, CNT_W) && timing_fits(T_CL, CNT_W) &&
          timing_fits(T_CWL, CNT_W) && timing_fits(T_BURST, CNT_W) &&
          timing_fits(T_WR, CNT_W) && timing_fits(T_RP, CNT_W) &&
          timing_fits(T_RFC, CNT_W) && timing_fits(T_REFI, CNT_W))) begin : g_bad_timing
        $error("dram_timing_ctrl: every T_* must be >= 1 and fit in CNT_W bits");
    end
    if (RD_SPAN[CNT_W] || WR_SPAN[CNT_W]) begin : g_bad_span
        $error("dram_timing_ctrl: derived read/write spans overflow CNT_W bits");
    end

    // The counter reads k-1 in cycle c0+k, so each event sits at its offset minus one.
    localparam logic [CNT_W-1:0] ACT_LAST      = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RD_DATA_FIRST = CNT_W'(T_CL - 1);
    localparam logic [CNT_W-1:0] RD_DATA_LAST  = CNT_W'(T_CL + T_BURST - 2);
    localparam logic [CNT_W-1:0] RD_LAST       = CNT_W'(RD_SPAN - 1'b1);
    localparam logic [CNT_W-1:0] WR_DATA_FIRST = CNT_W'(T_CWL - 1);
    localparam logic [CNT_W-1:0] WR_DATA_LAST  = CNT_W'(T_CWL + T_BURST - 2);
    localparam logic [CNT_W-1:0] WR_LAST       = CNT_W'(WR_SPAN - 1'b1);
    localparam logic [CNT_W-1:0] PRE_LAST      = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] REF_LAST      = CNT_W'(T_RFC - 1);

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ref_ack;

    assign ref_ack = (state_q == IDLE) && cmd_valid && (cmd == CMD_REF);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        tACT_done = 1'b0;
        tRD_done  = 1'b0;
        tWR_done  = 1'b0;
        tPRE_done = 1'b0;
        tREF_done = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    case (cmd)
                        CMD_ACT: state_d = ACT_W;
                        CMD_RD:  state_d = RD_W;
                        CMD_WR:  state_d = WR_W;
                        CMD_PRE: state_d = PRE_W;
                        CMD_REF: state_d = REF_W;
                        default: state_d = IDLE;
                    endcase
                end
            end
            ACT_W: tACT_done = (cnt_q == ACT_LAST);
            RD_W: begin
                rd_en    = (cnt_q >= RD_DATA_FIRST) && (cnt_q <= RD_DATA_LAST);
                tRD_done = (cnt_q == RD_LAST);
            end
            WR_W: begin
                wr_en    = (cnt_q >= WR_DATA_FIRST) && (cnt_q <= WR_DATA_LAST);
                tWR_done = (cnt_q == WR_LAST);
            end
            PRE_W:   tPRE_done = (cnt_q == PRE_LAST);
            REF_W:   tREF_done = (cnt_q == REF_LAST);
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign clear = tACT_done | tRD_done | tWR_done | tPRE_done | tREF_done;
    assign busy  = (state_q != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    dram_refresh_timer #(
        .T_REFI (T_REFI),
        .CNT_W  (CNT_W)
    ) u_refresh_timer (
        .CLK     (CLK),
        .RST     (RST),
        .ref_ack (ref_ack),
        .rf_req  (rf_req)
    );

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Self-checking bench for dram_timing_ctrl: directed scenarios plus random
// traffic, compared each cycle against an issue-cycle arithmetic model.
module tb_dram_timing_ctrl;
    import dram_pkg::*;

    localparam int CNT_W   = 16;
    localparam int T_RCD   = 4;
    localparam int T_CL    = 5;
    localparam int T_CWL   = 4;
    localparam int T_BURST = 4;
    localparam int T_WR    = 6;
    localparam int T_RP    = 4;
    localparam int T_RFC   = 16;
    localparam int T_REFI  = 64;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST, cmd_valid;
    cmd_t cmd;
    logic busy, tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done;
    logic rf_req, wr_en, rd_en, clear;

    dram_timing_ctrl #(
        .CNT_W(CNT_W), .T_RCD(T_RCD), .T_CL(T_CL), .T_CWL(T_CWL), .T_BURST(T_BURST),
        .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI)
    ) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd(cmd), .busy(busy),
        .tACT_done(tACT_done), .tWR_done(tWR_done), .tRD_done(tRD_done),
        .tPRE_done(tPRE_done), .tREF_done(tREF_done), .rf_req(rf_req),
        .wr_en(wr_en), .rd_en(rd_en), .clear(clear)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc, base;

    // Model: the one accepted command (issue cycle, done cycle, kind) and the
    // cycle at which the current refresh interval started counting from zero.
    bit   act_valid;
    int   act_c0, act_done;
    cmd_t act_kind;
    int   ref_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc - base, got, exp);
        end
    endtask

    function automatic int latency(input cmd_t k);
        case (k)
            CMD_ACT: return T_RCD;
            CMD_RD:  return T_CL + T_BURST;
            CMD_WR:  return T_CWL + T_BURST + T_WR;
            CMD_PRE: return T_RP;
            default: return T_RFC;
        endcase
    endfunction

    function automatic bit model_busy(input int n);
        return act_valid && (n > act_c0) && (n <= act_done);
    endfunction

    // One clock cycle: drive inputs, check every output mid-cycle, advance model.
    task automatic step(input logic rst, input logic v, input cmd_t c);
        bit win, done;
        RST       = rst;
        cmd_valid = v;
        cmd       = c;
        @(negedge CLK);
        win  = model_busy(cyc);
        done = win && (cyc == act_done);
        check("busy",      busy,      win);
        check("tACT_done", tACT_done, done && act_kind == CMD_ACT);
        check("tRD_done",  tRD_done,  done && act_kind == CMD_RD);
        check("tWR_done",  tWR_done,  done && act_kind == CMD_WR);
        check("tPRE_done", tPRE_done, done && act_kind == CMD_PRE);
        check("tREF_done", tREF_done, done && act_kind == CMD_REF);
        check("clear",     clear,     done);
        check("rd_en", rd_en, win && act_kind == CMD_RD &&
              cyc >= act_c0 + T_CL && cyc <= act_c0 + T_CL + T_BURST - 1);
        check("wr_en", wr_en, win && act_kind == CMD_WR &&
              cyc >= act_c0 + T_CWL && cyc <= act_c0 + T_CWL + T_BURST - 1);
        check("rf_req", rf_req, (cyc - ref_start) >= T_REFI);
        if (rst) begin
            act_valid = 1'b0;
            ref_start = cyc + 1;
        end else if (v) begin
            if (win) begin
                $display("note: protocol violation, %s while busy at cycle %0d (ignored)",
                         c.name(), cyc - base);
            end else begin
                act_valid = 1'b1;
                act_c0    = cyc;
                act_done  = cyc + latency(c);
                act_kind  = c;
                if (c == CMD_REF) ref_start = cyc + 1;
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic restart();
        step(1'b1, 1'b0, CMD_ACT);
        base = cyc;
    endtask

    task automatic idle_until(input int k);
        while (cyc - base < k) step(1'b0, 1'b0, CMD_ACT);
    endtask

    task automatic issue(input cmd_t c);
        step(1'b0, 1'b1, c);
    endtask

    initial begin
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = CMD_ACT;
        repeat (2) @(posedge CLK);
        #1;
        cyc       = 0;
        base      = 0;
        act_valid = 1'b0;
        ref_start = 0;

        // ACT at 10: done/clear at 14, busy 11..14.
        idle_until(10);
        issue(CMD_ACT);
        idle_until(20);

        // RD at 0: rd_en 5..8, done at 9.
        restart();
        issue(CMD_RD);
        idle_until(12);

        // WR at 0: wr_en 4..7, done at 14; RD at 7 is ignored.
        restart();
        issue(CMD_WR);
        idle_until(7);
        issue(CMD_RD);
        idle_until(17);

        // Refresh from reset: rf_req at 64, REF at 70, done 86, next rf_req 135.
        restart();
        idle_until(70);
        issue(CMD_REF);
        idle_until(140);

        // REF coincident with the threshold cycle: rf_req stays low.
        restart();
        idle_until(63);
        issue(CMD_REF);
        idle_until(130);

        // Reset during PRE aborts it; ACT at 6 completes at 10.
        restart();
        issue(CMD_PRE);
        idle_until(3);
        step(1'b1, 1'b0, CMD_ACT);
        idle_until(6);
        issue(CMD_ACT);
        idle_until(12);

        // Random traffic with occasional resets and rare protocol violations.
        restart();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(1'b1, 1'b0, CMD_ACT);
            end else if ($urandom_range(0, model_busy(cyc) ? 40 : 2) == 0) begin
                issue(cmd_t'($urandom_range(0, 4)));
            end else begin
                step(1'b0, 1'b0, cmd_t'($urandom_range(0, 4)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
